// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
// Select codes name where the next PC comes from; the top uses them for counting.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_TRAP  = 3'd3,
        SEL_FAULT = 3'd4
    } pc_sel_t;

    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEFAULT_FAULT_VECTOR = 64'h100;
    localparam int          DEFAULT_INSTR_BYTES  = 4;

    // Every select except HOLD moves the PC and therefore counts as a fetch.
    function automatic logic sel_moves_pc(input pc_sel_t sel);
        return sel != SEL_HOLD;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next PC in RUN: trap, redirect (alignment-checked),
// hold for halt/stall, else sequential increment.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              INSTR_BYTES = DEFAULT_INSTR_BYTES,
    parameter logic [XLEN-1:0] FAULT_PC    = '0
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inc_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            halt_req_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] next_pc_o,
    output pc_sel_t         sel_o,
    output logic            fault_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic misaligned;
    assign misaligned = |(redirect_target_i & ALIGN_MASK);

    always_comb begin
        next_pc_o = pc_i;
        sel_o     = SEL_HOLD;
        fault_o   = 1'b0;
        if (trap_valid_i) begin
            // Trap targets come from mtvec and are trusted as-is.
            next_pc_o = trap_target_i;
            sel_o     = SEL_TRAP;
        end else if (redirect_valid_i) begin
            if (misaligned) begin
                next_pc_o = FAULT_PC;
                sel_o     = SEL_FAULT;
                fault_o   = 1'b1;
            end else begin
                next_pc_o = redirect_target_i;
                sel_o     = SEL_REDIR;
            end
        end else if (halt_req_i || stall_i) begin
            next_pc_o = pc_i;
            sel_o     = SEL_HOLD;
        end else begin
            next_pc_o = inc_pc_i;
            sel_o     = SEL_INC;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address register with BOOT/RUN/HALTED control, misaligned-redirect
// fault pulse and a count of PC updates made while running.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [63:0] FAULT_VECTOR = DEFAULT_FAULT_VECTOR,
    parameter int          INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            misalign_fault,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count,
    output logic [1:0]      dbg_state
);

    localparam logic [XLEN-1:0] RST_PC   = RESET_VECTOR[XLEN-1:0];
    localparam logic [XLEN-1:0] FAULT_PC = FAULT_VECTOR[XLEN-1:0];
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] sel_pc;
    pc_sel_t         sel;
    logic            sel_fault;

    assign pc_plus = pc_q + PC_STEP;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .FAULT_PC    (FAULT_PC)
    ) u_next_sel (
        .pc_i              (pc_q),
        .inc_pc_i          (pc_plus),
        .trap_valid_i      (trap_valid),
        .trap_target_i     (trap_target),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .halt_req_i        (halt_req),
        .stall_i           (stall),
        .next_pc_o         (sel_pc),
        .sel_o             (sel),
        .fault_o           (sel_fault)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                pc_d    = sel_pc;
                fault_d = sel_fault;
                if (sel_moves_pc(sel)) count_d = count_q + 1'b1;
                // HOLD with halt_req means no trap or redirect outranked the halt.
                if (sel == SEL_HOLD && halt_req) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (trap_valid) begin
                    pc_d    = trap_target;
                    state_d = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RST_PC;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid       = (state_q == ST_RUN);
    assign halted         = (state_q == ST_HALTED);
    assign misalign_fault = fault_q;
    assign fetch_count    = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table for a 4-byte
// instance plus a hand sequence comparing 4-byte and 2-byte alignment.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, trap_valid, halt_req, resume;
    logic [63:0] redirect_target, trap_target;

    logic [63:0] pc4, plus4, cnt4;
    logic        valid4, fault4, halted4;
    logic [1:0]  st4;
    logic [63:0] pc2, plus2, cnt2;
    logic        valid2, fault2, halted2;
    logic [1:0]  st2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(64), .RESET_VECTOR(64'h1000), .FAULT_VECTOR(64'h100), .INSTR_BYTES(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc4), .pc_plus(plus4), .pc_valid(valid4), .misalign_fault(fault4),
        .halted(halted4), .fetch_count(cnt4), .dbg_state(st4)
    );

    pc_sequencer #(.XLEN(64), .RESET_VECTOR(64'h1000), .FAULT_VECTOR(64'h100), .INSTR_BYTES(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc2), .pc_plus(plus2), .pc_valid(valid2), .misalign_fault(fault2),
        .halted(halted2), .fetch_count(cnt2), .dbg_state(st2)
    );

    typedef struct {
        logic        rst, stl, rv;
        logic [63:0] rt;
        logic        tv;
        logic [63:0] tt;
        logic        hlt, res;
        logic [63:0] e_pc;
        logic        e_valid, e_halted, e_fault;
        logic [63:0] e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rst, logic stl, logic rv, logic [63:0] rt,
                                logic tv, logic [63:0] tt, logic hlt, logic res,
                                logic [63:0] e_pc, logic e_valid, logic e_halted,
                                logic e_fault, logic [63:0] e_cnt, logic [1:0] e_st);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.rt = rt; v.tv = tv; v.tt = tt;
        v.hlt = hlt; v.res = res; v.e_pc = e_pc; v.e_valid = e_valid;
        v.e_halted = e_halted; v.e_fault = e_fault; v.e_cnt = e_cnt; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rv, input logic [63:0] rt,
                         input logic tv, input logic [63:0] tt, input logic hlt, input logic res);
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = rt;
        trap_valid = tv; trap_target = tt; halt_req = hlt; resume = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rst stl rv rt                     tv tt      hlt res  e_pc                   val hal flt cnt  state
        vecs[0]  = mk(1, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1000,              0, 0, 0, 0,  ST_BOOT);
        vecs[1]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1000,              1, 0, 0, 0,  ST_RUN);
        vecs[2]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1004,              1, 0, 0, 1,  ST_RUN);
        vecs[3]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1008,              1, 0, 0, 2,  ST_RUN);
        vecs[4]  = mk(0, 0, 1, 64'h2000,              0, 64'h0,   0, 0, 64'h2000,              1, 0, 0, 3,  ST_RUN);
        vecs[5]  = mk(0, 1, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h2000,              1, 0, 0, 3,  ST_RUN);
        vecs[6]  = mk(0, 1, 1, 64'h3000,              0, 64'h0,   0, 0, 64'h3000,              1, 0, 0, 4,  ST_RUN);
        vecs[7]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h3004,              1, 0, 0, 5,  ST_RUN);
        vecs[8]  = mk(0, 0, 1, 64'h3002,              0, 64'h0,   0, 0, 64'h100,               1, 0, 1, 6,  ST_RUN);
        vecs[9]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h104,               1, 0, 0, 7,  ST_RUN);
        vecs[10] = mk(0, 0, 1, 64'h40,                0, 64'h0,   0, 0, 64'h40,                1, 0, 0, 8,  ST_RUN);
        vecs[11] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   1, 0, 64'h40,                0, 1, 0, 8,  ST_HALTED);
        vecs[12] = mk(0, 0, 1, 64'h3000,              0, 64'h0,   0, 0, 64'h40,                0, 1, 0, 8,  ST_HALTED);
        vecs[13] = mk(0, 1, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h40,                0, 1, 0, 8,  ST_HALTED);
        vecs[14] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   1, 0, 64'h40,                0, 1, 0, 8,  ST_HALTED);
        vecs[15] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h40,                0, 1, 0, 8,  ST_HALTED);
        vecs[16] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 1, 64'h40,                1, 0, 0, 8,  ST_RUN);
        vecs[17] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h44,                1, 0, 0, 9,  ST_RUN);
        vecs[18] = mk(0, 1, 0, 64'h0,                 0, 64'h0,   1, 0, 64'h44,                0, 1, 0, 9,  ST_HALTED);
        vecs[19] = mk(0, 0, 0, 64'h0,                 1, 64'h800, 0, 1, 64'h800,               1, 0, 0, 9,  ST_RUN);
        vecs[20] = mk(0, 0, 1, 64'h3000,              1, 64'h900, 0, 0, 64'h900,               1, 0, 0, 10, ST_RUN);
        vecs[21] = mk(0, 0, 0, 64'h0,                 1, 64'hA00, 1, 0, 64'hA00,               1, 0, 0, 11, ST_RUN);
        vecs[22] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'hA04,               1, 0, 0, 12, ST_RUN);
        vecs[23] = mk(0, 0, 0, 64'h0,                 1, 64'hB02, 0, 0, 64'hB02,               1, 0, 0, 13, ST_RUN);
        vecs[24] = mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 14, ST_RUN);
        vecs[25] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h0,                 1, 0, 0, 15, ST_RUN);
        vecs[26] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   1, 0, 64'h0,                 0, 1, 0, 15, ST_HALTED);
        vecs[27] = mk(1, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1000,              0, 0, 0, 0,  ST_BOOT);
        vecs[28] = mk(1, 0, 0, 64'h0,                 1, 64'h500, 0, 1, 64'h1000,              0, 0, 0, 0,  ST_BOOT);
        vecs[29] = mk(0, 0, 1, 64'h2000,              1, 64'h500, 1, 0, 64'h1000,              1, 0, 0, 0,  ST_RUN);
        vecs[30] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   0, 0, 64'h1004,              1, 0, 0, 1,  ST_RUN);
        vecs[31] = mk(0, 1, 1, 64'h3001,              0, 64'h0,   0, 0, 64'h100,               1, 0, 1, 2,  ST_RUN);
        vecs[32] = mk(0, 0, 1, 64'h3002,              0, 64'h0,   0, 0, 64'h100,               1, 0, 1, 3,  ST_RUN);
        vecs[33] = mk(0, 0, 0, 64'h0,                 0, 64'h0,   1, 0, 64'h100,               0, 1, 0, 3,  ST_HALTED);

        drive(1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        #2;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rt,
                  vecs[i].tv, vecs[i].tt, vecs[i].hlt, vecs[i].res);
            tick();
            check($sformatf("v%0d pc_out", i),   pc4,                 vecs[i].e_pc);
            check($sformatf("v%0d pc_plus", i),  plus4,               vecs[i].e_pc + 64'd4);
            check($sformatf("v%0d pc_valid", i), {63'b0, valid4},     {63'b0, vecs[i].e_valid});
            check($sformatf("v%0d halted", i),   {63'b0, halted4},    {63'b0, vecs[i].e_halted});
            check($sformatf("v%0d fault", i),    {63'b0, fault4},     {63'b0, vecs[i].e_fault});
            check($sformatf("v%0d count", i),    cnt4,                vecs[i].e_cnt);
            check($sformatf("v%0d state", i),    {62'b0, st4},        {62'b0, vecs[i].e_st});
        end

        // Same misaligned-by-2 redirect on both granules.
        drive(1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        check("ib2 reset pc", pc2, 64'h1000);
        check("ib2 reset count", cnt2, 64'h0);
        drive(0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 1, 64'h3002, 0, 64'h0, 0, 0);
        tick();
        check("ib4 redir3002 pc", pc4, 64'h100);
        check("ib4 redir3002 fault", {63'b0, fault4}, 64'h1);
        check("ib2 redir3002 pc", pc2, 64'h3002);
        check("ib2 redir3002 fault", {63'b0, fault2}, 64'h0);
        check("ib2 redir3002 plus", plus2, 64'h3004);
        drive(0, 0, 1, 64'h3001, 0, 64'h0, 0, 0);
        tick();
        check("ib2 redir3001 pc", pc2, 64'h100);
        check("ib2 redir3001 fault", {63'b0, fault2}, 64'h1);
        check("ib4 redir3001 fault", {63'b0, fault4}, 64'h1);
        drive(0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        check("ib2 inc pc", pc2, 64'h102);
        check("ib2 inc fault", {63'b0, fault2}, 64'h0);
        check("ib2 count", cnt2, 64'd3);
        check("ib4 inc pc", pc4, 64'h104);
        check("ib4 inc fault", {63'b0, fault4}, 64'h0);

        // Reset taken from RUN.
        drive(1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        check("run reset pc", pc4, 64'h1000);
        check("run reset count", cnt4, 64'h0);
        check("run reset valid", {63'b0, valid4}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
